// File: rtl/ps2_game_keys.sv
// Game key decoder behind a PS/2 receiver: accepts bytes by snapshot stability and decodes make/break/E0.
// Optional WASD aliases are enabled by defining KEY_WASD_EN.
module ps2_game_keys #(
    parameter int IDLE_CYCLES = 20000,
    parameter int CNT_W       = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_in,
    output logic        key_left,
    output logic        key_right,
    output logic        key_jump,
    output logic        key_shoot,
    output logic        key_restart,
    output logic        jump_press,
    output logic        jump_release,
    output logic        byte_stb,
    output logic [7:0]  byte_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(IDLE_CYCLES - 1);

    localparam logic [7:0] CODE_E0      = 8'hE0;
    localparam logic [7:0] CODE_F0      = 8'hF0;
    localparam logic [7:0] CODE_LEFT    = 8'h6B;
    localparam logic [7:0] CODE_RIGHT   = 8'h74;
    localparam logic [7:0] CODE_JUMP    = 8'h12;
    localparam logic [7:0] CODE_SHOOT   = 8'h1A;
    localparam logic [7:0] CODE_RESTART = 8'h2D;
`ifdef KEY_WASD_EN
    localparam logic [7:0] CODE_A       = 8'h1C;
    localparam logic [7:0] CODE_D       = 8'h23;
    localparam logic [7:0] CODE_W       = 8'h1D;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0
    } state_t;

    logic [15:0]      key_q;
    logic [15:0]      key_q_prev;
    logic [15:0]      last_word;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_next;
    logic             accept;

    state_t           state;
    logic             left_reg;
    logic             right_reg;
    logic             jump_reg;
    logic             shoot_reg;
    logic             restart_reg;
    logic             jump_d;
`ifdef KEY_WASD_EN
    logic             a_held;
    logic             d_held;
    logic             w_held;
`endif

    // A word is accepted exactly once, on the cycle the counter reaches IDLE_CYCLES-1;
    // saturation at IDLE_CYCLES keeps a long-held word from firing again.
    always_comb begin
        stab_next = stab_cnt;
        if (key_q != key_q_prev) begin
            stab_next = '0;
        end else if (stab_cnt != CNT_MAX) begin
            stab_next = stab_cnt + 1'b1;
        end
        accept = (key_q == key_q_prev) && (stab_next == CNT_ACC) && (key_q != last_word);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            key_q_prev <= '0;
            last_word  <= '0;
            stab_cnt   <= '0;
            byte_stb   <= 1'b0;
            byte_data  <= '0;
        end else begin
            key_q      <= key_in;
            key_q_prev <= key_q;
            stab_cnt   <= stab_next;
            byte_stb   <= accept;
            if (accept) begin
                byte_data <= key_q[7:0];
                last_word <= key_q;
            end
        end
    end

    // Decode FSM; advances only on accepted bytes, so keys follow byte_stb by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            left_reg    <= 1'b0;
            right_reg   <= 1'b0;
            jump_reg    <= 1'b0;
            shoot_reg   <= 1'b0;
            restart_reg <= 1'b0;
`ifdef KEY_WASD_EN
            a_held      <= 1'b0;
            d_held      <= 1'b0;
            w_held      <= 1'b0;
`endif
        end else if (byte_stb) begin
            case (state)
                S_IDLE: begin
                    if (byte_data == CODE_E0) begin
                        state <= S_E0;
                    end else if (byte_data == CODE_F0) begin
                        state <= S_F0;
                    end else begin
                        state <= S_IDLE;
                        if (byte_data == CODE_JUMP)    jump_reg    <= 1'b1;
                        if (byte_data == CODE_SHOOT)   shoot_reg   <= 1'b1;
                        if (byte_data == CODE_RESTART) restart_reg <= 1'b1;
`ifdef KEY_WASD_EN
                        if (byte_data == CODE_A)       a_held      <= 1'b1;
                        if (byte_data == CODE_D)       d_held      <= 1'b1;
                        if (byte_data == CODE_W)       w_held      <= 1'b1;
`endif
                    end
                end
                S_E0: begin
                    if (byte_data == CODE_F0) begin
                        state <= S_E0F0;
                    end else begin
                        // E0 12 (fake shift) and any other extended code fall through unmapped
                        state <= S_IDLE;
                        if (byte_data == CODE_LEFT)  left_reg  <= 1'b1;
                        if (byte_data == CODE_RIGHT) right_reg <= 1'b1;
                    end
                end
                S_F0: begin
                    state <= S_IDLE;
                    if (byte_data == CODE_JUMP)    jump_reg    <= 1'b0;
                    if (byte_data == CODE_SHOOT)   shoot_reg   <= 1'b0;
                    if (byte_data == CODE_RESTART) restart_reg <= 1'b0;
`ifdef KEY_WASD_EN
                    if (byte_data == CODE_A)       a_held      <= 1'b0;
                    if (byte_data == CODE_D)       d_held      <= 1'b0;
                    if (byte_data == CODE_W)       w_held      <= 1'b0;
`endif
                end
                S_E0F0: begin
                    state <= S_IDLE;
                    if (byte_data == CODE_LEFT)  left_reg  <= 1'b0;
                    if (byte_data == CODE_RIGHT) right_reg <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KEY_WASD_EN
    assign key_left  = left_reg  | a_held;
    assign key_right = right_reg | d_held;
    assign key_jump  = jump_reg  | w_held;
`else
    assign key_left  = left_reg;
    assign key_right = right_reg;
    assign key_jump  = jump_reg;
`endif
    assign key_shoot   = shoot_reg;
    assign key_restart = restart_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_d <= 1'b0;
        end else begin
            jump_d <= key_jump;
        end
    end

    // Edge pulses are mutually exclusive by construction and vanish with reset.
    assign jump_press   = key_jump & ~jump_d;
    assign jump_release = ~key_jump & jump_d;

endmodule

// File: tb/tb_ps2_game_keys.sv
// Directed bench for ps2_game_keys with a short stability window; expected values are hand-derived.
// Build with KEY_WASD_EN defined to exercise the alias expectations.
module tb_ps2_game_keys;

    localparam int IDLE = 40;
    localparam int WIN  = IDLE + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] key_in;
    logic        key_left, key_right, key_jump, key_shoot, key_restart;
    logic        jump_press, jump_release, byte_stb;
    logic [7:0]  byte_data;

    ps2_game_keys #(.IDLE_CYCLES(IDLE), .CNT_W(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_jump    (key_jump),
        .key_shoot   (key_shoot),
        .key_restart (key_restart),
        .jump_press  (jump_press),
        .jump_release(jump_release),
        .byte_stb    (byte_stb),
        .byte_data   (byte_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt, stb_lat, press_cnt, rel_cnt, both_cnt;
    logic [7:0] stb_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        stb_cnt = 0; stb_lat = 0; press_cnt = 0; rel_cnt = 0; both_cnt = 0; stb_data = 8'h00;
    endtask

    // Samples outputs after each falling edge; cycle i follows the i-th rising edge.
    task automatic watch(input int cycles);
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            if (byte_stb) begin
                if (stb_cnt == 0) begin
                    stb_lat  = i;
                    stb_data = byte_data;
                end
                stb_cnt++;
            end
            if (jump_press)   press_cnt++;
            if (jump_release) rel_cnt++;
            if (jump_press && jump_release) both_cnt++;
        end
    endtask

    // Caller is at a falling edge; drive a new snapshot and observe one full window.
    task automatic send(input string tag, input logic [15:0] w, input bit exp_stb);
        clear_counts();
        key_in = w;
        watch(WIN);
        check({tag, "_stb_cnt"}, stb_cnt, exp_stb ? 1 : 0);
        check({tag, "_both"}, both_cnt, 0);
        if (exp_stb) begin
            check({tag, "_lat"}, stb_lat, IDLE + 1);
            check({tag, "_data"}, {24'h0, stb_data}, {24'h0, w[7:0]});
        end
        $display("txn %s key_in=%04h stb=%0d data=%02h keys(LRJSR)=%b%b%b%b%b",
                 tag, w, stb_cnt, stb_data, key_left, key_right, key_jump, key_shoot, key_restart);
    endtask

    task automatic check_keys(input string tag, input logic [4:0] exp);
        check({tag, "_keys"}, {27'h0, key_left, key_right, key_jump, key_shoot, key_restart}, {27'h0, exp});
    endtask

    logic [4:0] wasd_on;

    initial begin
        rst_n  = 1'b0;
        key_in = 16'h0000;
        #1;
        check("reset_async_keys", {27'h0, key_left, key_right, key_jump, key_shoot, key_restart}, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_stb", {31'h0, byte_stb}, 32'h0);
        check("reset_data", {24'h0, byte_data}, 32'h0);
        check("reset_pulses", {30'h0, jump_press, jump_release}, 32'h0);
        rst_n = 1'b1;

        // 1: jump make and break with pulses
        send("t1_make", 16'h0012, 1'b1);
        check_keys("t1_make", 5'b00100);
        check("t1_press", press_cnt, 1);
        check("t1_no_rel", rel_cnt, 0);
        send("t1_f0", 16'h12F0, 1'b1);
        check_keys("t1_f0", 5'b00100);
        send("t1_break", 16'hF012, 1'b1);
        check_keys("t1_break", 5'b00000);
        check("t1_release", rel_cnt, 1);
        check("t1_no_press", press_cnt, 0);
        send("t1_same_word", 16'hF012, 1'b0);

        // 2: extended left, re-make, break, repeated break
        send("t2_e0", 16'h00E0, 1'b1);
        send("t2_make", 16'hE06B, 1'b1);
        check_keys("t2_make", 5'b10000);
        send("t2_re_e0", 16'h6BE0, 1'b1);
        send("t2_remake", 16'hE06B, 1'b1);
        check_keys("t2_remake", 5'b10000);
        send("t2_e0b", 16'h6BE0, 1'b1);
        send("t2_e0f0", 16'hE0F0, 1'b1);
        check_keys("t2_e0f0", 5'b10000);
        send("t2_break", 16'hF06B, 1'b1);
        check_keys("t2_break", 5'b00000);
        send("t2_e0c", 16'h6BE0, 1'b1);
        send("t2_e0f0b", 16'hE0F0, 1'b1);
        send("t2_rebreak", 16'hF06B, 1'b1);
        check_keys("t2_rebreak", 5'b00000);

        // 3: fake shift ignored, FSM back to idle
        send("t3_e0", 16'h6BE0, 1'b1);
        send("t3_fake", 16'hE012, 1'b1);
        check_keys("t3_fake", 5'b00000);
        send("t3_shoot", 16'h121A, 1'b1);
        check_keys("t3_shoot", 5'b00010);

        // 4: bouncing snapshot, only the settled value is accepted
        clear_counts();
        for (int k = 0; k < 9; k++) begin
            key_in = (k % 2 == 0) ? 16'h0033 : 16'h0034;
            watch(IDLE / 2);
        end
        check("t4_no_stb_while_toggling", stb_cnt, 0);
        send("t4_settle", 16'h0034, 1'b1);
        check_keys("t4_settle", 5'b00010);

        // 5: reset in the middle of a break prefix
        send("t5_jump", 16'h3412, 1'b1);
        check_keys("t5_jump", 5'b00110);
        send("t5_restart", 16'h122D, 1'b1);
        check_keys("t5_restart", 5'b00111);
        send("t5_f0", 16'h2DF0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_async_keys", {27'h0, key_left, key_right, key_jump, key_shoot, key_restart}, 32'h0);
        check("t5_async_misc", {29'h0, byte_stb, jump_press, jump_release}, 32'h0);
        clear_counts();
        watch(3);
        rst_n = 1'b1;
        check("t5_no_release_in_rst", rel_cnt, 0);
        send("t5_post", 16'h002D, 1'b1);
        check("t5_no_release_after", rel_cnt, 0);
        check_keys("t5_post", 5'b00001);

        // 6: A alias versus arrow left
`ifdef KEY_WASD_EN
        wasd_on = 5'b10001;
`else
        wasd_on = 5'b00001;
`endif
        send("t6_a", 16'h2D1C, 1'b1);
        check_keys("t6_a", wasd_on);
        send("t6_e0", 16'h1CE0, 1'b1);
        send("t6_arrow", 16'hE06B, 1'b1);
        check_keys("t6_arrow", 5'b10001);
        send("t6_f0", 16'h6BF0, 1'b1);
        send("t6_a_break", 16'hF01C, 1'b1);
        check_keys("t6_a_break", 5'b10001);
        send("t6_e0b", 16'h1CE0, 1'b1);
        send("t6_e0f0", 16'hE0F0, 1'b1);
        send("t6_arrow_break", 16'hF06B, 1'b1);
        check_keys("t6_arrow_break", 5'b00001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
